reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port integer register file with a write-back scoreboard and a sequential post-reset clear. Replaces the single-read-pair register file in the core top. It serves `READ_PORTS` registered operand reads per cycle to the decode/ALU stage and accepts one write-back per cycle. It tracks which registers have an in-flight producer, so issue logic can stall on RAW hazards.

## Interface
Parameters:
- `XLEN`, 32, data width in bits.
- `REG_COUNT`, 32, number of architectural registers (16 for RV32E); may be a non-power-of-two.
- `READ_PORTS`, 2, number of independent read ports (1..4).
- `AW`, `$clog2(REG_COUNT)`, address width (derived, not overridden).

Ports:
- `iClk` in 1: single clock.
- `iRst` in 1: reset, asynchronous, active-high.
- `oReady` in/out: out 1: high once the clear sequence is finished.
- `iRdEn` in `READ_PORTS`: per-port read request.
- `iRdAddr` in `READ_PORTS`×`AW`: per-port read address.
- `oRdData` out `READ_PORTS`×`XLEN`: per-port read data, registered.
- `oRdValid` out `READ_PORTS`: per-port data-valid, one cycle after `iRdEn`.
- `oRdBusy` out `READ_PORTS`: per-port scoreboard busy flag for the address read.
- `iWrEn` in 1: write-back enable.
- `iWrAddr` in `AW`: write-back address.
- `iWrData` in `XLEN`: write-back data.
- `iIssueEn` in 1: an instruction with a destination register issued.
- `iIssueRd` in `AW`: destination of the issued instruction.

## Operation
- FSM states are CLEAR and RUN.
- Reset asserted → CLEAR, clear counter = 1, all busy bits 0, `oReady`=0, all `oRdValid`=0, `oRdData`=0, `oRdBusy`=0.
- CLEAR: each cycle writes 0 to register[counter] and increments the counter. After writing `REG_COUNT-1`, transition to RUN.
- CLEAR: `iWrEn`, `iIssueEn` and `iRdEn` are ignored, and `oRdValid` stays 0.
- RUN: `oReady`=1. Normal operation.
- Register 0 is hardwired: reads return 0, and writes and issues to 0 are dropped.
- Addresses ≥ `REG_COUNT` (non-power-of-two case): reads return 0 with busy 0, and writes and issues are dropped.
- Write: at the clock edge with `iWrEn`, register[`iWrAddr`] ← `iWrData`, and busy[`iWrAddr`] is cleared.
- Read bypass: if `iRdEn[p]` and `iWrEn` target the same nonzero address in the same cycle, `oRdData[p]` returns `iWrData` (write-first).
- Busy reported: `oRdBusy[p]` = busy[`iRdAddr[p]`] after that cycle's write-back clear, before that cycle's issue set.
- Simultaneous issue and write-back to the same address: the set wins and the bit ends at 1 (new producer).
- Multiple ports reading the same address all receive identical data and busy values.
- Reads without `iRdEn[p]`: `oRdData[p]`/`oRdBusy[p]` hold their previous values, and `oRdValid[p]`=0.

## Timing
- Read latency is 1 cycle: request at edge N, data/valid/busy visible after edge N+1.
- Write-to-read: a write at edge N is visible to a read issued in the same cycle via bypass, and to later reads through the array.
- Clear duration: `REG_COUNT-1` cycles after reset release; `oReady` rises on the following edge (31 cycles for `REG_COUNT`=32).
- Reset asserted mid-RUN or mid-CLEAR: all outputs return to reset values immediately, and the clear restarts from 1.
- Throughput: `READ_PORTS` reads + 1 write + 1 issue per cycle, with no stalls after `oReady`.

## Structure
- The shared core package holds `cXLEN`, the register-count constant, and a `tRegFileRd` struct {en, addr} and `tRegFileWr` struct {en, addr, data}, reused by decoder and write-back.
- Sub-module `reg_scoreboard` holds the `REG_COUNT`-bit busy vector with set/clear priority and per-port lookup.
- The data array must be reset-free so it infers as distributed RAM or flops.

## Test plan
- Reset release, `REG_COUNT`=32: `oReady` low for 31 cycles then high; reading reg 5 returns 0 with `oRdValid`=1 one cycle later.
- Write 0xDEADBEEF to reg 7, then read reg 7 on ports 0 and 1 next cycle → both return 0xDEADBEEF; write 0x1234 to reg 0, read reg 0 → 0.
- Same-cycle write 0xA5A5A5A5 to reg 3 and read reg 3 on port 1 → port 1 returns 0xA5A5A5A5.
- Issue rd=9, then read 9 → busy 1; write-back 9 alongside another issue of 9 → stays busy; write-back 9 alone → next read busy 0.
- `REG_COUNT`=24: write 0xFF to address 30, read address 30 → data 0, busy 0; issue to address 0 → busy stays 0.
- Assert `iRst` for one cycle during RUN after writing reg 4 = 0x55 → outputs reset immediately, clear reruns, and reg 4 reads 0 once `oReady` rises.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared core definitions for the integer register file.
// Holds the default data width and register count, the read/write request
// structs reused by decode and write-back, the controller state type, and
// the address legality rule shared by the array and the scoreboard.
package reg_file_mp_pkg;

   localparam int cXLEN      = 32;
   localparam int cREG_COUNT = 32;
   localparam int cREG_AW    = $clog2(cREG_COUNT);

   typedef struct packed {
      logic               en;
      logic [cREG_AW-1:0] addr;
   } tRegFileRd;

   typedef struct packed {
      logic               en;
      logic [cREG_AW-1:0] addr;
      logic [cXLEN-1:0]   data;
   } tRegFileWr;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } tRfState;

   // Register 0 is hardwired and addresses past the last register do not
   // exist (non-power-of-two register counts), so neither holds state.
   function automatic logic addrLegal(input int unsigned addr,
                                      input int unsigned regCount);
      return (addr != 0) && (addr < regCount);
   endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Write-back scoreboard: one busy bit per architectural register.
// Ports:
//   iClk, iRst       clock, async active-high reset (clears all busy bits)
//   iClrEn/iClrAddr  write-back clear of a busy bit (already qualified)
//   iSetEn/iSetAddr  issue of a new producer (already qualified)
//   iLookupAddr      per-read-port address to look up
//   oBusy            per-port busy, seen after this cycle's clear but
//                    before this cycle's set
module reg_scoreboard
   import reg_file_mp_pkg::*;
#(
   parameter int REG_COUNT  = cREG_COUNT,
   parameter int READ_PORTS = 2,
   parameter int AW         = $clog2(REG_COUNT)
) (
   input  logic                           iClk,
   input  logic                           iRst,
   input  logic                           iClrEn,
   input  logic [AW-1:0]                  iClrAddr,
   input  logic                           iSetEn,
   input  logic [AW-1:0]                  iSetAddr,
   input  logic [READ_PORTS-1:0][AW-1:0]  iLookupAddr,
   output logic [READ_PORTS-1:0]          oBusy
);

   logic [REG_COUNT-1:0] busy;
   logic [REG_COUNT-1:0] busyCleared;
   logic [REG_COUNT-1:0] busyNext;

   // Clear first, then set: an issue landing on the register being written
   // back is a new producer, so the bit must stay high.
   always_comb begin
      busyCleared = busy;
      busyNext    = busy;
      for (int i = 0; i < REG_COUNT; i++) begin
         busyCleared[i] = busy[i] && !(iClrEn && (iClrAddr == AW'(i)));
         busyNext[i]    = busyCleared[i] || (iSetEn && (iSetAddr == AW'(i)));
      end
   end

   always_comb begin
      oBusy = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         if (addrLegal(32'(iLookupAddr[p]), REG_COUNT)) begin
            oBusy[p] = busyCleared[iLookupAddr[p]];
         end
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         busy <= '0;
      end else begin
         busy <= busyNext;
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-back scoreboard and a
// sequential clear of every register after reset.
// Ports:
//   iClk, iRst        clock, async active-high reset
//   oReady            high once the post-reset clear has finished
//   iRdEn, iRdAddr    per-port read request and address
//   oRdData           per-port registered read data (write-first bypass)
//   oRdValid          per-port valid, one cycle after iRdEn
//   oRdBusy           per-port scoreboard busy for the address read
//   iWrEn/iWrAddr/iWrData  write-back port, also clears busy
//   iIssueEn/iIssueRd      issued destination, sets busy
//
// state | meaning
// ------+-----------------------------------------------------------------
// CLEAR | writing 0 to register[clrCnt], one per cycle; all requests ignored
// RUN   | normal reads, write-back and issue; oReady high
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int XLEN       = cXLEN,
   parameter int REG_COUNT  = cREG_COUNT,
   parameter int READ_PORTS = 2,
   parameter int AW         = $clog2(REG_COUNT)
) (
   input  logic                            iClk,
   input  logic                            iRst,
   output logic                            oReady,
   input  logic [READ_PORTS-1:0]           iRdEn,
   input  logic [READ_PORTS-1:0][AW-1:0]   iRdAddr,
   output logic [READ_PORTS-1:0][XLEN-1:0] oRdData,
   output logic [READ_PORTS-1:0]           oRdValid,
   output logic [READ_PORTS-1:0]           oRdBusy,
   input  logic                            iWrEn,
   input  logic [AW-1:0]                   iWrAddr,
   input  logic [XLEN-1:0]                 iWrData,
   input  logic                            iIssueEn,
   input  logic [AW-1:0]                   iIssueRd
);

   localparam logic [AW-1:0] cLastIdx = AW'(REG_COUNT - 1);

   tRfState         state;
   tRfState         stateNext;
   logic [AW-1:0]   clrCnt;
   logic [AW-1:0]   clrCntNext;

   logic [XLEN-1:0] regArray [REG_COUNT];
   logic            arrWe;
   logic [AW-1:0]   arrAddr;
   logic [XLEN-1:0] arrData;

   logic            wrOk;
   logic            issueOk;
   logic [READ_PORTS-1:0] sbBusy;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state  <= CLEAR;
         clrCnt <= AW'(1);
      end else begin
         state  <= stateNext;
         clrCnt <= clrCntNext;
      end
   end

   // The clear sequence and write-back share the single array write port.
   always_comb begin
      stateNext  = state;
      clrCntNext = clrCnt;
      arrWe      = 1'b0;
      arrAddr    = iWrAddr;
      arrData    = iWrData;
      wrOk       = 1'b0;
      issueOk    = 1'b0;
      case (state)
         CLEAR: begin
            arrWe      = 1'b1;
            arrAddr    = clrCnt;
            arrData    = '0;
            clrCntNext = clrCnt + AW'(1);
            if (clrCnt == cLastIdx) begin
               stateNext = RUN;
            end
         end
         RUN: begin
            wrOk    = iWrEn    && addrLegal(32'(iWrAddr), REG_COUNT);
            issueOk = iIssueEn && addrLegal(32'(iIssueRd), REG_COUNT);
            arrWe   = wrOk;
         end
         default: stateNext = CLEAR;
      endcase
   end

   assign oReady = (state == RUN);

   // No reset on the array so it can map to distributed RAM.
   always_ff @(posedge iClk) begin
      if (arrWe) begin
         regArray[arrAddr] <= arrData;
      end
   end

   reg_scoreboard #(
      .REG_COUNT  (REG_COUNT),
      .READ_PORTS (READ_PORTS),
      .AW         (AW)
   ) uScoreboard (
      .iClk        (iClk),
      .iRst        (iRst),
      .iClrEn      (wrOk),
      .iClrAddr    (iWrAddr),
      .iSetEn      (issueOk),
      .iSetAddr    (iIssueRd),
      .iLookupAddr (iRdAddr),
      .oBusy       (sbBusy)
   );

   // Unrequested ports keep their last data/busy; only valid drops.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         oRdValid <= '0;
         oRdData  <= '0;
         oRdBusy  <= '0;
      end else begin
         for (int p = 0; p < READ_PORTS; p++) begin
            oRdValid[p] <= 1'b0;
            if ((state == RUN) && iRdEn[p]) begin
               oRdValid[p] <= 1'b1;
               oRdBusy[p]  <= sbBusy[p];
               if (!addrLegal(32'(iRdAddr[p]), REG_COUNT)) begin
                  oRdData[p] <= '0;
               end else if (wrOk && (iWrAddr == iRdAddr[p])) begin
                  oRdData[p] <= iWrData;
               end else begin
                  oRdData[p] <= regArray[iRdAddr[p]];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a 32-register and a 24-register instance share
// clock and reset; one is selected at a time and driven from a common
// stimulus set, checked against a behavioural register-file model.
module tb_reg_file_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic sel;

   logic [1:0]       rdEn;
   logic [1:0][4:0]  rdAddr;
   logic             wrEn;
   logic [4:0]       wrAddr;
   logic [31:0]      wrData;
   logic             issueEn;
   logic [4:0]       issueRd;

   logic             aReady, bReady;
   logic [1:0]       aRdEn, bRdEn;
   logic [1:0][4:0]  aRdAddr, bRdAddr;
   logic [1:0][31:0] aRdData, bRdData;
   logic [1:0]       aRdValid, bRdValid, aRdBusy, bRdBusy;
   logic             aWrEn, bWrEn, aIssueEn, bIssueEn;

   assign aRdEn    = sel ? 2'b00 : rdEn;
   assign bRdEn    = sel ? rdEn  : 2'b00;
   assign aRdAddr  = rdAddr;
   assign bRdAddr  = rdAddr;
   assign aWrEn    = sel ? 1'b0 : wrEn;
   assign bWrEn    = sel ? wrEn : 1'b0;
   assign aIssueEn = sel ? 1'b0 : issueEn;
   assign bIssueEn = sel ? issueEn : 1'b0;

   logic             obsReady;
   logic [1:0]       obsValid, obsBusy;
   logic [1:0][31:0] obsData;
   assign obsReady = sel ? bReady   : aReady;
   assign obsValid = sel ? bRdValid : aRdValid;
   assign obsBusy  = sel ? bRdBusy  : aRdBusy;
   assign obsData  = sel ? bRdData  : aRdData;

   reg_file_mp dutA (
      .iClk(clk), .iRst(rst), .oReady(aReady),
      .iRdEn(aRdEn), .iRdAddr(aRdAddr), .oRdData(aRdData),
      .oRdValid(aRdValid), .oRdBusy(aRdBusy),
      .iWrEn(aWrEn), .iWrAddr(wrAddr), .iWrData(wrData),
      .iIssueEn(aIssueEn), .iIssueRd(issueRd)
   );

   reg_file_mp #(.REG_COUNT(24)) dutB (
      .iClk(clk), .iRst(rst), .oReady(bReady),
      .iRdEn(bRdEn), .iRdAddr(bRdAddr), .oRdData(bRdData),
      .oRdValid(bRdValid), .oRdBusy(bRdBusy),
      .iWrEn(bWrEn), .iWrAddr(wrAddr), .iWrData(wrData),
      .iIssueEn(bIssueEn), .iIssueRd(issueRd)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: register contents, busy flags, and the expected
   // (held) output registers of each read port.
   logic [31:0]      mReg  [32];
   bit               mBusy [32];
   int               rc;
   int               edges;
   logic [1:0][31:0] eData;
   logic [1:0]       eBusy;
   logic [1:0]       eValid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(input int a);
      return (a != 0) && (a < rc);
   endfunction

   function automatic logic [4:0] pick(input int maxA);
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, maxA));
   endfunction

   task automatic setIdle();
      rdEn    = '0;
      rdAddr  = '0;
      wrEn    = 1'b0;
      wrAddr  = '0;
      wrData  = '0;
      issueEn = 1'b0;
      issueRd = '0;
   endtask

   task automatic randStim(input int maxA);
      rdEn      = 2'($urandom_range(0, 3));
      rdAddr[0] = pick(maxA);
      rdAddr[1] = pick(maxA);
      wrEn      = 1'($urandom_range(0, 1));
      wrAddr    = pick(maxA);
      wrData    = $urandom;
      issueEn   = ($urandom_range(0, 2) == 0);
      issueRd   = pick(maxA);
   endtask

   // One clock: predict from current inputs and model state, advance the
   // model, then compare every output half a cycle after the edge.
   task automatic tick();
      bit running;
      running = (edges >= rc - 1);
      if (running) begin
         for (int p = 0; p < 2; p++) begin
            int a;
            a = int'(rdAddr[p]);
            eValid[p] = rdEn[p];
            if (rdEn[p]) begin
               if (!legal(a)) begin
                  eData[p] = '0;
                  eBusy[p] = 1'b0;
               end else begin
                  bit hit;
                  hit = wrEn && legal(int'(wrAddr)) && (int'(wrAddr) == a);
                  eData[p] = hit ? wrData : mReg[a];
                  eBusy[p] = mBusy[a] && !hit;
               end
            end
         end
         if (wrEn && legal(int'(wrAddr))) begin
            mReg[wrAddr]  = wrData;
            mBusy[wrAddr] = 1'b0;
         end
         if (issueEn && legal(int'(issueRd))) mBusy[issueRd] = 1'b1;
      end else begin
         eValid = '0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
      chk("ready", 32'(obsReady), 32'(edges >= rc - 1));
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("valid%0d", p), 32'(obsValid[p]), 32'(eValid[p]));
         chk($sformatf("data%0d", p), obsData[p], eData[p]);
         chk($sformatf("busy%0d", p), 32'(obsBusy[p]), 32'(eBusy[p]));
      end
   endtask

   task automatic doReset(input int newRc);
      rst = 1'b1;
      #1;
      chk("rst_ready", 32'(obsReady), 32'd0);
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("rst_valid%0d", p), 32'(obsValid[p]), 32'd0);
         chk($sformatf("rst_data%0d", p), obsData[p], 32'd0);
         chk($sformatf("rst_busy%0d", p), 32'(obsBusy[p]), 32'd0);
      end
      rc    = newRc;
      edges = 0;
      for (int i = 0; i < 32; i++) begin
         mReg[i]  = '0;
         mBusy[i] = 1'b0;
      end
      eData  = '0;
      eBusy  = '0;
      eValid = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      sel   = 1'b0;
      rst   = 1'b0;
      rc    = 32;
      edges = 0;
      setIdle();
      @(negedge clk);

      // 32-register instance: clear with random (ignored) traffic
      doReset(32);
      for (int i = 0; i < 31; i++) begin
         randStim(31);
         tick();
      end
      setIdle();
      chk("ready_up", 32'(obsReady), 32'd1);

      rdEn = 2'b01; rdAddr[0] = 5'd5;
      tick();
      chk("rd5_valid", 32'(obsValid[0]), 32'd1);
      chk("rd5_data", obsData[0], 32'd0);

      setIdle(); wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'hDEADBEEF;
      tick();
      setIdle(); rdEn = 2'b11; rdAddr[0] = 5'd7; rdAddr[1] = 5'd7;
      tick();
      chk("rd7_p0", obsData[0], 32'hDEADBEEF);
      chk("rd7_p1", obsData[1], 32'hDEADBEEF);

      setIdle(); wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'h1234;
      tick();
      setIdle(); rdEn = 2'b01; rdAddr[0] = 5'd0;
      tick();
      chk("rd0_zero", obsData[0], 32'd0);

      setIdle(); wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'hA5A5A5A5;
      rdEn = 2'b10; rdAddr[1] = 5'd3;
      tick();
      chk("bypass_p1", obsData[1], 32'hA5A5A5A5);

      setIdle(); issueEn = 1'b1; issueRd = 5'd9;
      tick();
      setIdle(); rdEn = 2'b01; rdAddr[0] = 5'd9;
      tick();
      chk("busy9_issued", 32'(obsBusy[0]), 32'd1);

      setIdle(); wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'h99;
      issueEn = 1'b1; issueRd = 5'd9;
      tick();
      setIdle(); rdEn = 2'b01; rdAddr[0] = 5'd9;
      tick();
      chk("busy9_setwins", 32'(obsBusy[0]), 32'd1);

      setIdle(); wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'h9A;
      tick();
      setIdle(); rdEn = 2'b10; rdAddr[1] = 5'd9;
      tick();
      chk("busy9_cleared", 32'(obsBusy[1]), 32'd0);
      chk("rd9_data", obsData[1], 32'h9A);

      for (int i = 0; i < 400; i++) begin
         randStim(12);
         tick();
      end

      // Mid-run reset with non-zero outputs present
      setIdle(); wrEn = 1'b1; wrAddr = 5'd4; wrData = 32'h55;
      issueEn = 1'b1; issueRd = 5'd9;
      tick();
      setIdle(); rdEn = 2'b11; rdAddr[0] = 5'd4; rdAddr[1] = 5'd9;
      tick();
      chk("pre_rst_rd4", obsData[0], 32'h55);
      chk("pre_rst_busy9", 32'(obsBusy[1]), 32'd1);
      setIdle();
      doReset(32);
      for (int i = 0; i < 31; i++) tick();
      rdEn = 2'b01; rdAddr[0] = 5'd4;
      tick();
      chk("post_rst_rd4", obsData[0], 32'd0);

      // 24-register instance
      setIdle();
      sel = 1'b1;
      doReset(24);
      for (int i = 0; i < 23; i++) begin
         randStim(31);
         tick();
      end
      setIdle();
      chk("ready24_up", 32'(obsReady), 32'd1);

      wrEn = 1'b1; wrAddr = 5'd30; wrData = 32'hFF;
      issueEn = 1'b1; issueRd = 5'd30;
      tick();
      setIdle(); rdEn = 2'b01; rdAddr[0] = 5'd30;
      tick();
      chk("oor_data", obsData[0], 32'd0);
      chk("oor_busy", 32'(obsBusy[0]), 32'd0);

      setIdle(); issueEn = 1'b1; issueRd = 5'd0;
      tick();
      setIdle(); rdEn = 2'b10; rdAddr[1] = 5'd0;
      tick();
      chk("zero_busy", 32'(obsBusy[1]), 32'd0);

      setIdle(); wrEn = 1'b1; wrAddr = 5'd23; wrData = 32'hC0FFEE;
      tick();
      setIdle(); rdEn = 2'b01; rdAddr[0] = 5'd23;
      tick();
      chk("rd23_last", obsData[0], 32'hC0FFEE);

      for (int i = 0; i < 300; i++) begin
         randStim(31);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
